mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the word address width of the shared RAM port.
REQ-002 SHALL have parameter DATA_W, default 16, the word width.
REQ-003 SHALL have the port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have, for each requester n in {0,1}, the port: req_n  in  1  access request; held high until granted.
REQ-006 SHALL have, for each n, the port: we_n  in  1  1 = write, 0 = read; held stable with req_n.
REQ-007 SHALL have, for each n, the port: addr_n  in  ADDR_W  word address; held stable with req_n.
REQ-008 SHALL have, for each n, the port: wdata_n  in  DATA_W  write data; held stable with req_n.
REQ-009 SHALL have, for each n, the port: gnt_n  out  1  combinational; the access is accepted at the rising edge that ends the cycle in which gnt_n is high.
REQ-010 SHALL have, for each n, the port: rvalid_n  out  1  registered; one-cycle pulse marking read data on rdata_n.
REQ-011 SHALL have, for each n, the port: rdata_n  out  DATA_W  read data; meaningful only while rvalid_n is high.
REQ-012 SHALL have the port: ram_en  out  1  write enable to the RAM port; 1 = write.
REQ-013 SHALL have the port: ram_addr  out  ADDR_W  RAM port address.
REQ-014 SHALL have the port: ram_wdata  out  DATA_W  RAM port write data.
REQ-015 SHALL have the port: ram_rdata  in  DATA_W  registered RAM port output, valid in the cycle after the address is presented.
REQ-016 SHALL have the port: conflict_cnt  out  16  count of cycles in which req_0 and req_1 were both high.

Function
REQ-017 SHALL grant at most one requester per cycle; gnt_0 and gnt_1 are never high together.
REQ-018 SHALL, with exactly one req high, grant that requester in the same cycle regardless of priority.
REQ-019 SHALL, with both req high, grant the requester named by register prio (0 or 1).
REQ-020 SHALL, on every edge where a grant occurs, set prio to the non-granted requester; prio is unchanged when no grant occurs.
REQ-021 SHALL drive ram_addr, ram_wdata and ram_en = we_n from the granted requester; with no grant, ram_en = 0, and ram_addr and ram_wdata hold the values from requester 0.
REQ-022 SHALL, for a granted read (we_n = 0) at edge E, assert rvalid_n for exactly the cycle following E, with rdata_n equal to ram_rdata.
REQ-023 SHALL NOT assert rvalid for granted writes.
REQ-024 SHALL register the owner of an in-flight read so that rdata is routed correctly while a new grant is issued in the same cycle, giving back-to-back throughput of one access per cycle.
REQ-025 SHALL route ram_rdata to both rdata_0 and rdata_1; rdata_n is qualified only by rvalid_n.
REQ-026 SHALL allow a requester that is granted to raise req again next cycle; under continuous dual requests, grants SHALL alternate 0,1,0,1...
REQ-027 SHALL increment conflict_cnt on each edge where req_0 and req_1 are both high, saturating at 16'hFFFF.
REQ-028 SHALL treat a read and a write to the same address in consecutive grants in RAM order: the later read returns the earlier write data.

Reset
REQ-029 SHALL, while reset is high, force prio = 0, rvalid_0 = rvalid_1 = 0, conflict_cnt = 0, and the registered read-owner cleared.
REQ-030 SHALL, when reset is asserted mid-read, discard the pending response; no rvalid SHALL follow reset release.
REQ-031 SHALL keep gnt_n and the ram_* outputs combinational from req/we/addr/wdata and prio; during reset, prio = 0.

Verification
REQ-032 SHALL cover a single read: req_1 = 1, we_1 = 0, addr_1 = 0x005, RAM holds 0xBEEF -> gnt_1 is high in cycle 0, rvalid_1 = 1 with rdata_1 = 0xBEEF in cycle 1, and rvalid_0 stays 0.
REQ-033 SHALL cover simultaneous requests after reset: req_0 and req_1 held high for 4 cycles -> grant order 0,1,0,1 and conflict_cnt = 4.
REQ-034 SHALL cover write then read: requester 0 writes 0x1234 to 0x3FF, then requester 1 reads 0x3FF -> rdata_1 = 0x1234 with rvalid_1.
REQ-035 SHALL cover back-to-back reads: requester 0 reads 0x001, then requester 1 reads 0x002 in the next cycle -> rvalid_0 and rvalid_1 in consecutive cycles with the correct data.
REQ-036 SHALL cover reset mid-read: reset asserted in the cycle after a read grant -> rvalid stays 0, prio = 0, conflict_cnt = 0.
REQ-037 SHALL cover saturation: a preloaded or forced conflict_cnt of 0xFFFE plus 3 conflict cycles -> conflict_cnt = 0xFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester round-robin arbiter for a single registered RAM port.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_0,
   input  logic              we_0,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic              req_1,
   input  logic              we_1,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_1,
   output logic              gnt_0,
   output logic              gnt_1,
   output logic              rvalid_0,
   output logic              rvalid_1,
   output logic [DATA_W-1:0] rdata_0,
   output logic [DATA_W-1:0] rdata_1,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [15:0]       conflict_cnt
);

   localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

   logic        r_prio;
   logic        r_rd_pend;
   logic        r_rd_owner;
   logic [15:0] r_conflict_cnt;
   logic        w_gnt_0;
   logic        w_gnt_1;
   logic        w_conflict;

   assign w_conflict = req_0 & req_1;
   assign w_gnt_0    = req_0 & (~req_1 | ~r_prio);
   assign w_gnt_1    = req_1 & (~req_0 |  r_prio);

   assign gnt_0     = w_gnt_0;
   assign gnt_1     = w_gnt_1;
   assign ram_en    = (w_gnt_0 & we_0) | (w_gnt_1 & we_1);
   assign ram_addr  = w_gnt_1 ? addr_1  : addr_0;
   assign ram_wdata = w_gnt_1 ? wdata_1 : wdata_0;

   // The read owner is captured at grant so a new grant can issue while the
   // previous read's data is still returning from the RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prio     <= 1'b0;
         r_rd_pend  <= 1'b0;
         r_rd_owner <= 1'b0;
      end else begin
         if (w_gnt_0) begin
            r_prio <= 1'b1;
         end else if (w_gnt_1) begin
            r_prio <= 1'b0;
         end
         r_rd_pend  <= (w_gnt_0 & ~we_0) | (w_gnt_1 & ~we_1);
         r_rd_owner <= w_gnt_1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_conflict_cnt <= 16'h0000;
      end else if (w_conflict && (r_conflict_cnt != c_CNT_MAX)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'h0001;
      end
   end

   assign rvalid_0     = r_rd_pend & ~r_rd_owner;
   assign rvalid_1     = r_rd_pend &  r_rd_owner;
   assign rdata_0      = ram_rdata;
   assign rdata_1      = ram_rdata;
   assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a registered RAM model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        req_0, we_0, req_1, we_1;
   logic [9:0]  addr_0, addr_1;
   logic [15:0] wdata_0, wdata_1;
   logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
   logic [15:0] rdata_0, rdata_1;
   logic        ram_en;
   logic [9:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic [15:0] conflict_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] mem [0:1023];

   mem_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
      .clk(clk), .reset(reset),
      .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .gnt_0(gnt_0), .gnt_1(gnt_1),
      .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
      .rdata_0(rdata_0), .rdata_1(rdata_1),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered single-port RAM: data for the presented address appears next cycle.
   always @(posedge clk) begin
      if (ram_en) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr0(input logic [9:0] a, input logic [15:0] d);
      req_0 = 1'b1; we_0 = 1'b1; addr_0 = a; wdata_0 = d;
      #1;
      check("wr0_gnt", {31'd0, gnt_0}, 32'd1);
      check("wr0_en", {31'd0, ram_en}, 32'd1);
      cyc();
      req_0 = 1'b0; we_0 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req_0 = 1'b0; we_0 = 1'b0; addr_0 = 10'h155; wdata_0 = 16'h0;
      req_1 = 1'b0; we_1 = 1'b0; addr_1 = 10'h0AA; wdata_1 = 16'h0;
      #3;
      check("rst_rvalid0", {31'd0, rvalid_0}, 32'd0);
      check("rst_rvalid1", {31'd0, rvalid_1}, 32'd0);
      check("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
      check("idle_gnt", {30'd0, gnt_1, gnt_0}, 32'd0);
      check("idle_en", {31'd0, ram_en}, 32'd0);
      check("idle_addr", {22'd0, ram_addr}, 32'h155);
      #9 reset = 1'b0;
      cyc();

      // preload RAM through requester 0
      wr0(10'h005, 16'hBEEF);
      wr0(10'h001, 16'h1111);
      wr0(10'h002, 16'h2222);

      // single read by requester 1
      req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h005;
      #1;
      check("rd1_gnt1", {31'd0, gnt_1}, 32'd1);
      check("rd1_gnt0", {31'd0, gnt_0}, 32'd0);
      check("rd1_addr", {22'd0, ram_addr}, 32'h005);
      check("rd1_en", {31'd0, ram_en}, 32'd0);
      cyc();
      req_1 = 1'b0;
      check("rd1_rvalid1", {31'd0, rvalid_1}, 32'd1);
      check("rd1_rdata1", {16'd0, rdata_1}, 32'hBEEF);
      check("rd1_rvalid0", {31'd0, rvalid_0}, 32'd0);
      cyc();
      check("rd1_pulse_end", {31'd0, rvalid_1}, 32'd0);

      // back-to-back reads: 0 then 1
      req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'h001;
      #1;
      check("b2b_gnt0", {31'd0, gnt_0}, 32'd1);
      cyc();
      req_0 = 1'b0;
      req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h002;
      #1;
      check("b2b_gnt1", {31'd0, gnt_1}, 32'd1);
      check("b2b_rvalid0", {31'd0, rvalid_0}, 32'd1);
      check("b2b_rdata0", {16'd0, rdata_0}, 32'h1111);
      check("b2b_rvalid1_early", {31'd0, rvalid_1}, 32'd0);
      cyc();
      req_1 = 1'b0;
      check("b2b_rvalid1", {31'd0, rvalid_1}, 32'd1);
      check("b2b_rdata1", {16'd0, rdata_1}, 32'h2222);
      check("b2b_rvalid0_end", {31'd0, rvalid_0}, 32'd0);
      cyc();

      // write then read of the same address
      req_0 = 1'b1; we_0 = 1'b1; addr_0 = 10'h3FF; wdata_0 = 16'h1234;
      #1;
      check("wr_gnt0", {31'd0, gnt_0}, 32'd1);
      check("wr_wdata", {16'd0, ram_wdata}, 32'h1234);
      check("wr_addr", {22'd0, ram_addr}, 32'h3FF);
      cyc();
      req_0 = 1'b0; we_0 = 1'b0;
      req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h3FF;
      #1;
      check("wr_no_rvalid0", {31'd0, rvalid_0}, 32'd0);
      check("wr_rd_gnt1", {31'd0, gnt_1}, 32'd1);
      cyc();
      req_1 = 1'b0;
      check("wrrd_rvalid1", {31'd0, rvalid_1}, 32'd1);
      check("wrrd_rdata1", {16'd0, rdata_1}, 32'h1234);

      // leave prio pointing at requester 1, then reset
      wr0(10'h3FE, 16'h5A5A);
      reset = 1'b1;
      #4 reset = 1'b0;
      cyc();
      check("rst2_cnt", {16'd0, conflict_cnt}, 32'd0);

      // continuous dual reads: grants alternate starting with 0
      req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'h001;
      req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h002;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("dual_gnt", {30'd0, gnt_1, gnt_0}, (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i > 0) begin
            check("dual_rvalid", {30'd0, rvalid_1, rvalid_0}, (i % 2 == 1) ? 32'd1 : 32'd2);
            check("dual_rdata", {16'd0, (i % 2 == 1) ? rdata_0 : rdata_1},
                  (i % 2 == 1) ? 32'h1111 : 32'h2222);
         end
         cyc();
      end
      req_0 = 1'b0; req_1 = 1'b0;
      #1;
      check("dual_cnt", {16'd0, conflict_cnt}, 32'd4);
      check("dual_last_rvalid1", {31'd0, rvalid_1}, 32'd1);
      check("dual_last_rdata1", {16'd0, rdata_1}, 32'h2222);
      cyc();

      // reset in the cycle after a read grant by requester 0
      req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'h001;
      #1;
      check("rstmid_gnt0", {31'd0, gnt_0}, 32'd1);
      cyc();
      req_0 = 1'b0;
      reset = 1'b1;
      #1;
      check("rstmid_rvalid0", {31'd0, rvalid_0}, 32'd0);
      check("rstmid_cnt", {16'd0, conflict_cnt}, 32'd0);
      cyc();
      reset = 1'b0;
      cyc();
      check("rstmid_after", {30'd0, rvalid_1, rvalid_0}, 32'd0);
      req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b1; we_1 = 1'b1;
      #1;
      check("rstmid_prio", {30'd0, gnt_1, gnt_0}, 32'd1);

      // saturation of the conflict counter
      for (int i = 0; i < 65534; i++) cyc();
      check("sat_pre", {16'd0, conflict_cnt}, 32'hFFFE);
      for (int i = 0; i < 3; i++) cyc();
      check("sat_cnt", {16'd0, conflict_cnt}, 32'hFFFF);
      req_0 = 1'b0; req_1 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
